// File: rtl/frame_draw_scheduler_pkg.sv
// Shared types and default geometry for the frame draw scheduler and its scan counter.
// The note clip helper lives here so other drawers can apply the same keyboard boundary.
package frame_draw_scheduler_pkg;

  typedef enum logic [1:0] {
    FDS_IDLE,
    FDS_BG,
    FDS_NOTE,
    FDS_DONE
  } fds_state_e;

  localparam int FDS_SCREEN_W     = 160;
  localparam int FDS_SCREEN_H     = 120;
  localparam int FDS_KEYBOARD_TOP = 92;
  localparam int FDS_COLOUR_W     = 24;
  localparam int FDS_NOTE_TIMEOUT = 4096;

  localparam logic [4:0] FDS_RECORD = 5'd9;

  function automatic logic note_clipped(input logic [7:0] x, input logic [7:0] y,
                                        input logic [7:0] x_lim, input logic [7:0] y_lim);
    return (x >= x_lim) || (y >= y_lim);
  endfunction

endpackage

// File: rtl/frame_draw_scheduler_scan.sv
// Row-major x/y pixel counter with enable; wraps to (0,0) after the last pixel of the frame.
module screen_scan_counter #(
  parameter int W = 160,
  parameter int H = 120
) (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic       en_i,
  output logic [7:0] x_o,
  output logic [7:0] y_o,
  output logic       last_o
);

  localparam logic [7:0] LAST_X = 8'(W - 1);
  localparam logic [7:0] LAST_Y = 8'(H - 1);

  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (en_i) begin
      if (x_q == LAST_X) begin
        x_d = 8'd0;
        y_d = (y_q == LAST_Y) ? 8'd0 : y_q + 8'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      x_q <= 8'd0;
      y_q <= 8'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == LAST_X) && (y_q == LAST_Y);

endmodule

// File: rtl/frame_draw_scheduler.sv
// Per-frame VGA write sequencer: full-screen background scan, then an optional granted
// note-block pass, with frame-tick queuing (one deep) and overrun reporting.
module frame_draw_scheduler
  import frame_draw_scheduler_pkg::*;
#(
  parameter int         SCREEN_W     = FDS_SCREEN_W,
  parameter int         SCREEN_H     = FDS_SCREEN_H,
  parameter int         KEYBOARD_TOP = FDS_KEYBOARD_TOP,
  parameter int         COLOUR_W     = FDS_COLOUR_W,
  parameter int         NOTE_TIMEOUT = FDS_NOTE_TIMEOUT,
  parameter logic [4:0] RECORD_CODE  = FDS_RECORD
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                frameTick,
  input  logic [4:0]          currentState,
  input  logic [COLOUR_W-1:0] bgColour,
  output logic [7:0]          scanX,
  output logic [7:0]          scanY,
  input  logic                noteReq,
  output logic                noteGrant,
  input  logic                noteValid,
  input  logic [7:0]          noteX,
  input  logic [7:0]          noteY,
  input  logic [COLOUR_W-1:0] noteColour,
  input  logic                noteDone,
  output logic                vgaPlot,
  output logic [7:0]          vgaX,
  output logic [7:0]          vgaY,
  output logic [COLOUR_W-1:0] vgaColour,
  output logic                frameBusy,
  output logic                doneDrawing,
  output logic                overrun
);

  localparam int                TMO_W    = $clog2(NOTE_TIMEOUT) + 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(NOTE_TIMEOUT - 1);
  localparam logic [7:0]        X_LIM    = 8'(SCREEN_W);
  localparam logic [7:0]        Y_LIM    = 8'(KEYBOARD_TOP);

  fds_state_e          state_q;
  logic                pending_q, pending_d;
  logic [TMO_W-1:0]    tmo_q;
  logic                vga_plot_q;
  logic [7:0]          vga_x_q, vga_y_q;
  logic [COLOUR_W-1:0] vga_colour_q;
  logic                done_q, overrun_q;

  logic scan_en, scan_last, recording, tick_drop;

  assign scan_en   = (state_q == FDS_BG);
  assign recording = (currentState == RECORD_CODE);
  assign tick_drop = frameTick && (state_q != FDS_IDLE) && pending_q;

  screen_scan_counter #(
    .W(SCREEN_W),
    .H(SCREEN_H)
  ) u_scan (
    .clk_i   (clk),
    .resetn_i(resetn),
    .en_i    (scan_en),
    .x_o     (scanX),
    .y_o     (scanY),
    .last_o  (scan_last)
  );

  // A queued tick is consumed when a frame starts; a tick seen while one is queued is dropped.
  always_comb begin
    pending_d = pending_q;
    if (state_q == FDS_IDLE) begin
      pending_d = 1'b0;
    end else if ((state_q == FDS_DONE) && pending_q) begin
      pending_d = 1'b0;
    end else if (frameTick) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= FDS_IDLE;
      pending_q    <= 1'b0;
      tmo_q        <= '0;
      vga_plot_q   <= 1'b0;
      vga_x_q      <= 8'd0;
      vga_y_q      <= 8'd0;
      vga_colour_q <= '0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      vga_plot_q <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= tick_drop;
      pending_q  <= pending_d;
      case (state_q)
        FDS_IDLE: begin
          if (frameTick || pending_q) state_q <= FDS_BG;
        end
        FDS_BG: begin
          vga_plot_q   <= 1'b1;
          vga_x_q      <= scanX;
          vga_y_q      <= scanY;
          vga_colour_q <= bgColour;
          if (scan_last) begin
            tmo_q   <= '0;
            state_q <= (noteReq && !recording) ? FDS_NOTE : FDS_DONE;
          end
        end
        FDS_NOTE: begin
          tmo_q <= tmo_q + 1'b1;
          if (noteValid) begin
            vga_x_q      <= noteX;
            vga_y_q      <= noteY;
            vga_colour_q <= noteColour;
            vga_plot_q   <= !note_clipped(noteX, noteY, X_LIM, Y_LIM);
          end
          // A finished or pre-empted note pass is never an overrun, even on the timeout cycle.
          if ((noteValid && noteDone) || recording) begin
            state_q <= FDS_DONE;
          end else if (tmo_q == TMO_LAST) begin
            state_q   <= FDS_DONE;
            overrun_q <= 1'b1;
          end
        end
        FDS_DONE: begin
          done_q  <= 1'b1;
          state_q <= pending_q ? FDS_BG : FDS_IDLE;
        end
        default: state_q <= FDS_IDLE;
      endcase
    end
  end

  assign noteGrant   = (state_q == FDS_NOTE);
  assign frameBusy   = (state_q != FDS_IDLE);
  assign vgaPlot     = vga_plot_q;
  assign vgaX        = vga_x_q;
  assign vgaY        = vga_y_q;
  assign vgaColour   = vga_colour_q;
  assign doneDrawing = done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Scoreboard bench for frame_draw_scheduler: expected plots/pulses are queued with their cycle,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_frame_draw_scheduler;
  import frame_draw_scheduler_pkg::*;

  typedef struct packed {
    int          cyc;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [23:0] c;
  } plot_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        frameTick;
  logic [4:0]  currentState;
  logic [23:0] bgColour;
  logic [7:0]  scanX, scanY;
  logic        noteReq, noteGrant, noteValid, noteDone;
  logic [7:0]  noteX, noteY;
  logic [23:0] noteColour;
  logic        vgaPlot;
  logic [7:0]  vgaX, vgaY;
  logic [23:0] vgaColour;
  logic        frameBusy, doneDrawing, overrun;

  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  plot_t exp_q[$];
  int    done_exp[$];
  int    ovr_exp[$];
  plot_t e;

  function automatic logic [23:0] bg_col(input logic [7:0] x, input logic [7:0] y);
    return {x, y, x ^ y ^ 8'h5A};
  endfunction

  assign bgColour = bg_col(scanX, scanY);

  frame_draw_scheduler dut (
    .clk(clk), .resetn(resetn), .frameTick(frameTick), .currentState(currentState),
    .bgColour(bgColour), .scanX(scanX), .scanY(scanY), .noteReq(noteReq),
    .noteGrant(noteGrant), .noteValid(noteValid), .noteX(noteX), .noteY(noteY),
    .noteColour(noteColour), .noteDone(noteDone), .vgaPlot(vgaPlot), .vgaX(vgaX),
    .vgaY(vgaY), .vgaColour(vgaColour), .frameBusy(frameBusy),
    .doneDrawing(doneDrawing), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int t);
    while (cyc < t) step();
  endtask

  // Background pixel i of a frame whose BG state begins at cycle s appears at cycle s+1+i.
  task automatic push_bg(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      plot_t p;
      p.cyc = s + 1 + i;
      p.x   = 8'(i % 160);
      p.y   = 8'(i / 160);
      p.c   = bg_col(p.x, p.y);
      exp_q.push_back(p);
    end
  endtask

  task automatic drive_note(input logic [7:0] x, input logic [7:0] y, input logic [23:0] c,
                            input logic v, input logic d);
    plot_t p;
    noteX = x; noteY = y; noteColour = c; noteValid = v; noteDone = d;
    if (v && int'(x) < 160 && int'(y) < 92) begin
      p.cyc = cyc + 1; p.x = x; p.y = y; p.c = c;
      exp_q.push_back(p);
    end
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_plot"}, 64'(vgaPlot), 64'd0);
    check({tag, "_x"}, 64'(vgaX), 64'd0);
    check({tag, "_y"}, 64'(vgaY), 64'd0);
    check({tag, "_colour"}, 64'(vgaColour), 64'd0);
    check({tag, "_grant"}, 64'(noteGrant), 64'd0);
    check({tag, "_busy"}, 64'(frameBusy), 64'd0);
    check({tag, "_done"}, 64'(doneDrawing), 64'd0);
    check({tag, "_overrun"}, 64'(overrun), 64'd0);
    check({tag, "_scanx"}, 64'(scanX), 64'd0);
    check({tag, "_scany"}, 64'(scanY), 64'd0);
  endtask

  always @(negedge clk) begin
    if (vgaPlot === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL plot_unexpected at cycle %0d: got plot (%0d,%0d), required none", cyc, vgaX, vgaY);
      end else begin
        e = exp_q.pop_front();
        check("plot_cycle", 64'(cyc), 64'(e.cyc));
        check("plot_x", 64'(vgaX), 64'(e.x));
        check("plot_y", 64'(vgaY), 64'(e.y));
        check("plot_colour", 64'(vgaColour), 64'(e.c));
      end
    end
    if (doneDrawing === 1'b1) begin
      if (done_exp.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL done_unexpected at cycle %0d: got pulse, required none", cyc);
      end else check("done_cycle", 64'(cyc), 64'(done_exp.pop_front()));
    end
    if (overrun === 1'b1) begin
      if (ovr_exp.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL overrun_unexpected at cycle %0d: got pulse, required none", cyc);
      end else check("overrun_cycle", 64'(cyc), 64'(ovr_exp.pop_front()));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by cycle %0d, required finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s, k, n, t;
    logic [4:0] cs;
    resetn = 1'b0; frameTick = 1'b0; currentState = 5'd0; noteReq = 1'b0;
    noteValid = 1'b0; noteDone = 1'b0; noteX = 8'd0; noteY = 8'd0; noteColour = 24'd0;
    repeat (3) step();
    check_all_zero("reset");
    resetn = 1'b1;
    step(); step();
    check("idle_busy", 64'(frameBusy), 64'd0);

    // Frame 1: note request present but recording, so BG goes straight to DONE, then IDLE.
    noteReq = 1'b1; currentState = FDS_RECORD;
    frameTick = 1'b1; s = cyc + 1; push_bg(s, 19200);
    step(); frameTick = 1'b0;
    check("f1_busy", 64'(frameBusy), 64'd1);
    run_until(s + 19200);
    check("f1_no_grant", 64'(noteGrant), 64'd0);
    check("f1_done_busy", 64'(frameBusy), 64'd1);
    done_exp.push_back(s + 19201);
    step(); step();
    check("f1_idle_busy", 64'(frameBusy), 64'd0);

    // Frame 2: two ticks during BG, then a granted note pass ending on noteDone.
    do cs = 5'($urandom_range(0, 31)); while (cs == FDS_RECORD);
    currentState = cs;
    frameTick = 1'b1; s = cyc + 1; push_bg(s, 19200);
    step(); frameTick = 1'b0;
    run_until(s + int'($urandom_range(5, 5000)));
    frameTick = 1'b1; step(); frameTick = 1'b0;
    k = cyc + int'($urandom_range(0, 5000));
    run_until(k);
    frameTick = 1'b1; ovr_exp.push_back(k + 1); step(); frameTick = 1'b0;
    run_until(s + 19199);
    check("f2_bg_no_grant", 64'(noteGrant), 64'd0);
    step();
    check("f2_grant", 64'(noteGrant), 64'd1);
    drive_note(8'd10, 8'd20, 24'hA1B2C3, 1'b1, 1'b0);
    drive_note(8'd5, 8'd92, 24'h111111, 1'b1, 1'b0);
    drive_note(8'd160, 8'd10, 24'h222222, 1'b1, 1'b0);
    drive_note(8'd5, 8'd91, 24'($urandom), 1'b1, 1'b0);
    n = int'($urandom_range(3, 12));
    for (int i = 0; i < n; i++)
      drive_note(8'($urandom_range(0, 200)), 8'($urandom_range(0, 130)), 24'($urandom),
                 1'($urandom_range(0, 1)), 1'b0);
    check("f2_grant_held", 64'(noteGrant), 64'd1);
    drive_note(8'd10, 8'd20, 24'h0F0F0F, 1'b1, 1'b1);
    noteValid = 1'b0; noteDone = 1'b0;
    check("f2_grant_drop", 64'(noteGrant), 64'd0);
    done_exp.push_back(cyc + 1);
    s = cyc + 1; push_bg(s, 19200);
    step();
    check("f3_pending_busy", 64'(frameBusy), 64'd1);

    // Frame 3: grant held without noteDone until the timeout fires.
    run_until(s + 19200);
    check("f3_grant", 64'(noteGrant), 64'd1);
    t = s + 19200 + 4096;
    ovr_exp.push_back(t);
    done_exp.push_back(t + 1);
    for (int i = 0; i < 4096; i++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      frameTick = (i == 100);
      drive_note(8'($urandom_range(0, 200)), 8'($urandom_range(0, 130)), 24'($urandom),
                 v, v ? 1'b0 : 1'($urandom_range(0, 1)));
    end
    frameTick = 1'b0; noteValid = 1'b0; noteDone = 1'b0;
    check("f3_timeout_grant_drop", 64'(noteGrant), 64'd0);

    // Frame 4 starts from the tick queued during the note pass; reset lands mid-BG.
    noteReq = 1'b0;
    s = t + 1; push_bg(s, 100);
    run_until(s + 100);
    resetn = 1'b0;
    step();
    check_all_zero("midreset");
    resetn = 1'b1;
    repeat (3) step();
    check("post_reset_busy", 64'(frameBusy), 64'd0);
    check("plots_left", 64'(exp_q.size()), 64'd0);
    check("done_left", 64'(done_exp.size()), 64'd0);
    check("overrun_left", 64'(ovr_exp.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_draw_scheduler.md
Name: frame_draw_scheduler

Overview:
Sequences every write to the VGA adapter for one frame: a full-screen background/keyboard pass, then an optional note-block pass. It owns the pixel scan counter that feeds the combinational keyboard colour renderer. It grants the note-block drawer exclusive access to the plot port. It sits between the top-level state machine, the keyboard renderer, the note-block drawer and the VGA adapter.

Parameters:
SCREEN_W, 160, pixels per row
SCREEN_H, 120, rows per frame
KEYBOARD_TOP, 92, first row owned by the keyboard graphic; note pixels at or below it are clipped
COLOUR_W, 24, colour width
NOTE_TIMEOUT, 4096, max cycles of grant without noteDone
RECORD_CODE, `RECORD, currentState value that suppresses the note pass

Ports:
clk  in  1  system clock
resetn  in  1  synchronous reset, active-low
frameTick  in  1  one-cycle pulse requesting a new frame
currentState  in  5  top-level FSM state
bgColour  in  COLOUR_W  renderer colour for (scanX, scanY), combinational, same cycle
scanX  out  8  background scan column
scanY  out  8  background scan row
noteReq  in  1  note drawer has pixels for this frame
noteGrant  out  1  note drawer owns the plot port
noteValid  in  1  noteX/noteY/noteColour valid this cycle
noteX  in  8  note pixel column
noteY  in  8  note pixel row
noteColour  in  COLOUR_W  note pixel colour
noteDone  in  1  qualifies the last note pixel (ignored unless noteValid)
vgaPlot  out  1  write strobe to VGA adapter
vgaX  out  8  write column
vgaY  out  8  write row
vgaColour  out  COLOUR_W  write colour
frameBusy  out  1  high from BG entry until return to IDLE
doneDrawing  out  1  one-cycle pulse at end of frame
overrun  out  1  one-cycle pulse on dropped tick or note timeout

Behaviour:
- Reset (resetn=0 at posedge): state IDLE. All outputs 0, pending=0, scan and timeout counters 0. Applies mid-frame; grant drops on the same edge.
- FSM states: IDLE, BG, NOTE, DONE.
- IDLE: frameTick or pending -> BG, clear pending.
- BG:
  - Scan row-major. scanX increments 0..SCREEN_W-1; at SCREEN_W-1 it wraps to 0 and scanY increments.
  - vgaX/vgaY/vgaColour/vgaPlot are registered from scanX/scanY/bgColour (1-cycle latency), vgaPlot=1 each cycle.
  - Exactly SCREEN_W*SCREEN_H plots (19200).
  - After (159,119) is issued, the scan resets to (0,0). Next state is NOTE if noteReq=1 and currentState!=RECORD_CODE, else DONE.
- NOTE:
  - noteGrant=1 throughout. Each noteValid cycle registers the note pixel to the vga outputs (1-cycle latency).
  - vgaPlot=noteValid unless clipped: noteX>=SCREEN_W or noteY>=KEYBOARD_TOP.
  - noteValid&noteDone -> DONE, grant drops next edge.
  - Timeout counter clears on entry and counts every NOTE cycle. Reaching NOTE_TIMEOUT -> DONE plus overrun pulse.
  - currentState changing to RECORD_CODE mid-NOTE -> DONE, no overrun.
- DONE: doneDrawing=1 for one cycle, vgaPlot=0. Next state BG if pending, else IDLE.
- frameTick while not IDLE sets pending. A frameTick while pending is already 1 is dropped and produces an overrun pulse.
- frameTick in IDLE enters BG at the next edge; first plot appears 2 cycles after the tick.
- vgaPlot is never 1 in IDLE or DONE; noteGrant is never 1 outside NOTE.
- frameBusy=1 in BG, NOTE and DONE.

Decomposition:
- Shared header DefineMacros.vh gains FSM state encodings (FDS_IDLE..FDS_DONE), SCREEN_W/H and KEYBOARD_TOP defaults; RECORD is reused from it.
- One sub-module: screen_scan_counter (x/y row-major counter with enable, wrap and last-pixel flag), reusable by drawToScreen.

Test Plan:
- Reset, then frameTick with noteReq=0 -> 19200 consecutive vgaPlot cycles, first at (0,0) 2 cycles after the tick, last at (159,119). Then doneDrawing pulses once and the FSM returns to IDLE.
- noteReq=1, currentState!=RECORD -> noteGrant rises the cycle after the last BG plot. Pixels (10,20,colA) then (10,20,colB)+noteDone -> two plots in order, grant drops.
- Note pixels (5,92) and (160,10) -> vgaPlot stays 0 for both; (5,91) plots.
- noteReq=1 with currentState=RECORD -> no grant, DONE directly after BG.
- Grant held 4096 cycles without noteDone -> overrun pulse, grant drops, doneDrawing pulses.
- Two frameTicks during BG -> first sets pending, second pulses overrun; after DONE a second BG pass starts immediately. resetn=0 mid-BG -> all outputs 0 on the next edge.
